uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares a single UART transmitter between NUM_REQ byte-stream requesters, such as the crypto engine result stream, status/echo logic and debug, using round-robin arbitration. The block sits between the requester handshakes and the transmitter's start/busy interface. It sequences one byte at a time: issue, wait for the transmitter to accept, wait for completion, then enforce an inter-byte gap. With packet locking compiled in, a requester keeps the transmitter until it sends its last byte.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- GAP_CYCLES, 16: idle clocks after each byte completes before the next issue; 0 is legal.
- BUSY_TIMEOUT, 15: clocks allowed for tx_busy to rise after tx_start.
- LOCK_TIMEOUT, 1_000_000: clocks a locked grant may wait for the next byte before it is released.
- clock_fpga  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  8*NUM_REQ  byte for requester i is at [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of a packet; qualified by valid.
- req_ready  out  NUM_REQ  byte accepted; one-hot or zero.
- tx_data  out  8  byte presented to the transmitter.
- tx_start  out  1  one-cycle start pulse.
- tx_busy  in  1  transmitter is shifting a frame.
- grant_active  out  1  a requester currently owns the transmitter.
- grant_id  out  3  index of the owning requester.
- err_timeout  out  1  one-cycle pulse when BUSY_TIMEOUT or LOCK_TIMEOUT expires.

## Operation
- The state machine has the states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and GAP.
- IDLE: when any req_valid is high, select the first valid requester, searching upward from rr_ptr and wrapping modulo NUM_REQ. Latch grant_id, set grant_active and go to ISSUE. While no request is valid, stay in IDLE with grant_active=0.
- ISSUE: req_ready[grant_id] = req_valid[grant_id], combinationally.
  - On the accept edge, register tx_data from the granted byte, register last_seen from req_last, set tx_start=1 and go to WAIT_BUSY.
- WAIT_BUSY: tx_start is high only in the first cycle.
  - tx_busy=1: go to WAIT_DONE.
  - Counter reaches BUSY_TIMEOUT: pulse err_timeout and go to GAP (the byte is treated as sent).
- WAIT_DONE: go to GAP on the first cycle with tx_busy=0.
- GAP: count GAP_CYCLES clocks, then do one of the following:
  - Locked and last_seen=0: return to ISSUE with the same grant.
  - Otherwise: release the grant, set rr_ptr=(grant_id+1) mod NUM_REQ, and go to IDLE. The new grant is decided in the IDLE cycle.
- Locked ISSUE with req_valid[grant_id] low: count idle clocks. At LOCK_TIMEOUT, pulse err_timeout, release the grant and advance rr_ptr as in GAP.
- req_ready is never high outside ISSUE. At most one byte is in flight.
- Requests from other requesters that change during a grant have no effect until the grant is released.
- Reset mid-frame: all state clears immediately; the transmitter finishes its frame on its own. After reset, IDLE ignores tx_busy, and the first issue waits until tx_busy=0.

## Timing
- Reset values:
  - All outputs are 0.
  - rr_ptr=0, so requester 0 has first priority.
  - The state is IDLE and all counters are 0.
- Minimum latency from valid in IDLE to tx_start is 2 clocks: IDLE to ISSUE (1), then the accept edge (1).
- Byte-to-byte issue period within a packet is frame time + GAP_CYCLES + 2 clocks.
- tx_data is stable from tx_start until the next accept.
- Counters are 20-bit and saturate; there is no wrap-around.

## Configuration
- UART_ARB_LOCK_EN defined: packet locking as described above. A grant is held across bytes until a byte with req_last=1 is accepted or LOCK_TIMEOUT expires.
- Not defined:
  - req_last is ignored and LOCK_TIMEOUT logic is absent.
  - Every byte ends at GAP, then IDLE with rr_ptr advanced, so requesters interleave byte by byte.

## Test plan
- Single requester 2 sends 0xA5 with last=1, transmitter busy for 40 clocks -> tx_start 2 clocks after valid, tx_data=0xA5, grant released after GAP, rr_ptr=3.
- Requesters 0 and 1 held valid continuously, LOCK_EN off -> tx_data alternates req0, req1, req0, and req_ready never goes high for two requesters at once.
- LOCK_EN on: req1 sends 3-byte packet 0x11,0x22,0x33 (last on 0x33) while req0 is valid -> all three bytes from req1 go out before req0 is granted.
- tx_busy held 0 after tx_start -> err_timeout pulses BUSY_TIMEOUT clocks later and arbitration continues.
- LOCK_EN on: req3 drops valid mid-packet -> err_timeout pulses after LOCK_TIMEOUT idle clocks and the grant passes to the next valid requester.
- Reset asserted during WAIT_DONE -> next cycle all outputs are 0 and state is IDLE; a new request is not issued until tx_busy=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Define UART_ARB_LOCK_EN to hold a grant across bytes until a req_last byte is accepted.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int GAP_CYCLES   = 16,
   parameter int BUSY_TIMEOUT = 15,
   parameter int LOCK_TIMEOUT = 1_000_000
) (
   input  logic                 clock_fpga,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   input  logic [8*NUM_REQ-1:0] i_req_data,
   input  logic [NUM_REQ-1:0]   i_req_last,
   output logic [NUM_REQ-1:0]   o_req_ready,
   output logic [7:0]           o_tx_data,
   output logic                 o_tx_start,
   input  logic                 i_tx_busy,
   output logic                 o_grant_active,
   output logic [2:0]           o_grant_id,
   output logic                 o_err_timeout
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

   localparam logic [19:0] C_BUSY_END = 20'(BUSY_TIMEOUT - 1);
   localparam logic [19:0] C_GAP_END  = 20'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [2:0]  C_LAST_ID  = 3'(NUM_REQ - 1);

   state_t      r_state, w_next;
   logic [19:0] r_cnt;
   logic [2:0]  r_rr_ptr, r_grant_id, w_sel;
   logic [7:0]  r_tx_data, w_gnt_data;
   logic        r_tx_start, r_err;
   logic        w_any, w_gnt_valid, w_accept;
   logic        w_byte_end, w_gap_end, w_release, w_err;

`ifdef UART_ARB_LOCK_EN
   localparam logic [19:0] C_LOCK_END = 20'(LOCK_TIMEOUT - 1);
   logic r_last_seen, w_gnt_last;
`else
   logic w_unused_last;
   assign w_unused_last = ^i_req_last;
`endif

   // Offsets scanned from farthest to nearest so the requester closest to rr_ptr wins.
   always_comb begin
      w_any = 1'b0;
      w_sel = r_rr_ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (i_req_valid[i] &&
                ((int'(r_rr_ptr) + k == i) || (int'(r_rr_ptr) + k == i + NUM_REQ))) begin
               w_any = 1'b1;
               w_sel = 3'(i);
            end
         end
      end
   end

   always_comb begin
      w_gnt_valid = 1'b0;
      w_gnt_data  = '0;
`ifdef UART_ARB_LOCK_EN
      w_gnt_last  = 1'b0;
`endif
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant_id == 3'(i)) begin
            w_gnt_valid = i_req_valid[i];
            w_gnt_data  = i_req_data[8*i +: 8];
`ifdef UART_ARB_LOCK_EN
            w_gnt_last  = i_req_last[i];
`endif
         end
      end
   end

   // Accept is held off while the transmitter is still busy (e.g. a frame left over from reset).
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_rdy
      assign o_req_ready[g] = (r_state == ISSUE) && (r_grant_id == 3'(g)) &&
                              i_req_valid[g] && !i_tx_busy;
   end
   assign w_accept = |o_req_ready;

   always_comb begin
      w_next     = r_state;
      w_byte_end = 1'b0;
      w_gap_end  = 1'b0;
      w_release  = 1'b0;
      w_err      = 1'b0;
      case (r_state)
         IDLE:      if (w_any) w_next = ISSUE;
         ISSUE: begin
            if (w_accept) w_next = WAIT_BUSY;
`ifdef UART_ARB_LOCK_EN
            else if (!w_gnt_valid && r_cnt == C_LOCK_END) begin
               w_err     = 1'b1;
               w_release = 1'b1;
            end
`endif
         end
         WAIT_BUSY: begin
            if (i_tx_busy) w_next = WAIT_DONE;
            else if (r_cnt == C_BUSY_END) begin
               w_err      = 1'b1;
               w_byte_end = 1'b1;
            end
         end
         WAIT_DONE: if (!i_tx_busy) w_byte_end = 1'b1;
         GAP:       if (r_cnt == C_GAP_END) w_gap_end = 1'b1;
         default:   w_next = IDLE;
      endcase
      // A zero-length gap skips the GAP state entirely.
      if (w_byte_end) begin
         if (GAP_CYCLES == 0) w_gap_end = 1'b1;
         else                 w_next    = GAP;
      end
      if (w_gap_end) begin
`ifdef UART_ARB_LOCK_EN
         if (!r_last_seen) w_next    = ISSUE;
         else              w_release = 1'b1;
`else
         w_release = 1'b1;
`endif
      end
      if (w_release) w_next = IDLE;
   end

   always_ff @(posedge clock_fpga) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_rr_ptr   <= '0;
         r_grant_id <= '0;
         r_tx_data  <= '0;
         r_tx_start <= 1'b0;
         r_err      <= 1'b0;
`ifdef UART_ARB_LOCK_EN
         r_last_seen <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         // In ISSUE the counter only measures consecutive clocks without a valid byte.
         if (w_next != r_state || r_state == IDLE || (r_state == ISSUE && w_gnt_valid))
            r_cnt <= '0;
         else if (r_cnt != '1)
            r_cnt <= r_cnt + 20'd1;
         if (r_state == IDLE && w_any) r_grant_id <= w_sel;
         if (w_release) r_rr_ptr <= (r_grant_id == C_LAST_ID) ? 3'd0 : r_grant_id + 3'd1;
         if (w_accept) begin
            r_tx_data <= w_gnt_data;
`ifdef UART_ARB_LOCK_EN
            r_last_seen <= w_gnt_last;
`endif
         end
         r_tx_start <= w_accept;
         r_err      <= w_err;
      end
   end

   assign o_tx_data      = r_tx_data;
   assign o_tx_start     = r_tx_start;
   assign o_grant_active = (r_state != IDLE);
   assign o_grant_id     = r_grant_id;
   assign o_err_timeout  = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter and queue-based requesters.
// Build with UART_ARB_LOCK_EN defined to exercise packet locking.
module tb_uart_tx_arbiter;
   localparam int NR = 4, GAP = 16, BTO = 15, LTO = 40;

   logic            clk, rst;
   logic [NR-1:0]   req_valid, req_last, req_ready;
   logic [8*NR-1:0] req_data;
   logic [7:0]      tx_data;
   logic            tx_start, tx_busy, grant_active, err;
   logic [2:0]      grant_id;

   int cyc = 0, n_cmp = 0, n_bad = 0, viol = 0, err_cnt = 0, busy_cnt = 0, frame_len = 40;
   bit txm_en = 1;
   logic [8:0] rq [NR][$];
   logic [NR-1:0] rdy_prev = '0;
   int         tx_cyc[$];
   logic [7:0] tx_dat[$];
   logic [2:0] tx_gnt[$];

   uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(BTO), .LOCK_TIMEOUT(LTO)) dut (
      .clock_fpga(clk), .reset(rst),
      .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
      .o_req_ready(req_ready), .o_tx_data(tx_data), .o_tx_start(tx_start),
      .i_tx_busy(tx_busy), .o_grant_active(grant_active), .o_grant_id(grant_id),
      .o_err_timeout(err)
   );

   initial begin clk = 0; forever #5 clk = ~clk; end
   initial forever begin @(posedge clk); cyc++; end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(); @(posedge clk); #2; endtask

   task automatic drive(input int i);
      logic [8:0] e;
      if (rq[i].size() > 0) begin
         e = rq[i][0];
         req_valid[i] = 1'b1;
         req_data[8*i +: 8] = e[7:0];
         req_last[i] = e[8];
      end else begin
         req_valid[i] = 1'b0;
         req_last[i]  = 1'b0;
      end
   endtask

   task automatic push(input int i, input logic [7:0] d, input logic l);
      rq[i].push_back({l, d});
      drive(i);
   endtask

   task automatic wait_tx(input int n);
      for (int k = 0; k < 400 && tx_cyc.size() < n; k++) tick();
      chk("tx_count", 32'(tx_cyc.size() >= n), 1);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 400 && (grant_active || tx_busy); k++) tick();
      chk("idle", {30'd0, grant_active, tx_busy}, 0);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick();
   endtask

   // Requesters: pop a byte after the edge that accepted it.
   initial forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
         if (rdy_prev[i] && rq[i].size() > 0) rq[i].delete(0);
         drive(i);
      end
   end

   // Transmitter: busy from the tx_start cycle for frame_len clocks.
   initial forever begin
      @(posedge clk); #1;
      if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) tx_busy = 1'b0;
      end
      if (txm_en && tx_start) begin
         tx_busy  = 1'b1;
         busy_cnt = frame_len;
      end
   end

   initial forever begin
      @(posedge clk); #3;
      rdy_prev = req_ready;
      if ($countones(req_ready) > 1) viol++;
      if (err) err_cnt++;
      if (tx_start) begin
         tx_cyc.push_back(cyc);
         tx_dat.push_back(tx_data);
         tx_gnt.push_back(grant_id);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion exp finish");
      $fatal(1);
   end

   initial begin
      int c, t, t2, b;
      rst = 1; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 0;
      repeat (3) tick();
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_txdata", 32'(tx_data), 0);
      chk("rst_start", 32'(tx_start), 0);
      chk("rst_gact", 32'(grant_active), 0);
      chk("rst_gid", 32'(grant_id), 0);
      chk("rst_err", 32'(err), 0);
      rst = 0; tick();

      // single requester 2, long frame
      c = cyc; push(2, 8'hA5, 1);
      wait_tx(1); t = tx_cyc[0];
      chk("t1_latency", 32'(t - c), 2);
      chk("t1_data", 32'(tx_dat[0]), 32'hA5);
      chk("t1_gnt", 32'(tx_gnt[0]), 2);
      wait_until(t + 56); chk("t1_gap_hold", 32'(grant_active), 1);
      tick();             chk("t1_release", 32'(grant_active), 0);

      // rr_ptr=3 after requester 2: requester 3 beats requester 1
      frame_len = 5;
      push(1, 8'h31, 1); push(3, 8'h33, 1);
      wait_tx(3);
      chk("t2_gnt_a", 32'(tx_gnt[1]), 3); chk("t2_dat_a", 32'(tx_dat[1]), 32'h33);
      chk("t2_gnt_b", 32'(tx_gnt[2]), 1); chk("t2_dat_b", 32'(tx_dat[2]), 32'h31);
      wait_idle();

`ifdef UART_ARB_LOCK_EN
      b = tx_cyc.size();
      push(1, 8'h11, 0); push(1, 8'h22, 0); push(1, 8'h33, 1);
      wait_tx(b + 1); push(0, 8'h01, 1);
      wait_tx(b + 4);
      chk("t3_d0", 32'(tx_dat[b]),   32'h11); chk("t3_g0", 32'(tx_gnt[b]),   1);
      chk("t3_d1", 32'(tx_dat[b+1]), 32'h22); chk("t3_g1", 32'(tx_gnt[b+1]), 1);
      chk("t3_d2", 32'(tx_dat[b+2]), 32'h33); chk("t3_g2", 32'(tx_gnt[b+2]), 1);
      chk("t3_d3", 32'(tx_dat[b+3]), 32'h01); chk("t3_g3", 32'(tx_gnt[b+3]), 0);
`else
      b = tx_cyc.size();
      for (int j = 1; j <= 3; j++) begin
         push(0, 8'(j), 0); push(1, 8'(8'h80 + j), 0);
      end
      wait_tx(b + 6);
      for (int k = 0; k < 6; k++)
         chk($sformatf("t3_dat%0d", k), 32'(tx_dat[b+k]),
             (k % 2 == 0) ? 32'(1 + k / 2) : 32'(8'h81 + k / 2));
`endif
      wait_idle();

      // transmitter never goes busy
      txm_en = 0; b = tx_cyc.size();
      push(2, 8'h5A, 1);
      wait_tx(b + 1); t = tx_cyc[b];
      wait_until(t + 14); chk("t4_err_pre", 32'(err), 0);
      tick();             chk("t4_err_pulse", 32'(err), 1);
      tick();             chk("t4_err_end", 32'(err), 0);
      wait_until(t + 30); chk("t4_gap_hold", 32'(grant_active), 1);
      tick();             chk("t4_release", 32'(grant_active), 0);
      txm_en = 1; b = tx_cyc.size();
      push(3, 8'h6B, 1);
      wait_tx(b + 1); chk("t4_next_dat", 32'(tx_dat[b]), 32'h6B);
      wait_idle();

`ifdef UART_ARB_LOCK_EN
      // requester 3 stalls mid-packet
      b = tx_cyc.size();
      push(3, 8'hC1, 0); push(3, 8'hC2, 0);
      wait_tx(b + 1); push(0, 8'h0F, 1);
      wait_tx(b + 2); t2 = tx_cyc[b+1];
      chk("t5_locked_dat", 32'(tx_dat[b+1]), 32'hC2);
      wait_until(t2 + 61); chk("t5_err_pre", 32'(err), 0);
      tick();              chk("t5_err_pulse", 32'(err), 1);
      wait_tx(b + 3);
      chk("t5_next_lat", 32'(tx_cyc[b+2] - t2), 64);
      chk("t5_next_dat", 32'(tx_dat[b+2]), 32'h0F);
      chk("t5_next_gnt", 32'(tx_gnt[b+2]), 0);
      wait_idle();
`endif

      // reset during WAIT_DONE; transmitter keeps shifting its frame
      frame_len = 40; b = tx_cyc.size();
      push(1, 8'h77, 1);
      wait_tx(b + 1); t = tx_cyc[b];
      wait_until(t + 10); rst = 1;
      tick();
      chk("t6_ready", 32'(req_ready), 0);
      chk("t6_txdata", 32'(tx_data), 0);
      chk("t6_start", 32'(tx_start), 0);
      chk("t6_gact", 32'(grant_active), 0);
      chk("t6_gid", 32'(grant_id), 0);
      chk("t6_err", 32'(err), 0);
      rst = 0; push(2, 8'h99, 1);
      wait_until(t + 20);
      chk("t6_hold_ready", 32'(req_ready), 0);
      chk("t6_hold_gact", 32'(grant_active), 1);
      wait_tx(b + 2);
      chk("t6_issue_lat", 32'(tx_cyc[b+1] - t), 41);
      chk("t6_issue_dat", 32'(tx_dat[b+1]), 32'h99);
      wait_idle();

      chk("onehot_viol", 32'(viol), 0);
`ifdef UART_ARB_LOCK_EN
      chk("err_total", 32'(err_cnt), 2);
`else
      chk("err_total", 32'(err_cnt), 1);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
